// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the dffram port arbiter: WB FSM encoding, macro
// geometry and the design-select codes that own the SRAM port.
package sram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_DATA = 2'd1,
    WB_ACK  = 2'd2
  } wb_state_e;

  localparam int SRAM_AW = 6;
  localparam int SRAM_DW = 8;

  localparam logic [3:0] DSG_SEL_QCPU    = 4'd4;
  localparam logic [3:0] DSG_SEL_MC14500 = 4'd5;

  // Upstream helper for forming dsg_en from design_select.
  function automatic logic dsg_sel_uses_sram(input logic [3:0] design_select);
    return (design_select == DSG_SEL_QCPU) || (design_select == DSG_SEL_MC14500);
  endfunction

endpackage

// File: rtl/sram_port_arbiter.sv
// Arbitrates the 64x8 dffram between the Wishbone SRAM window and the active
// user design; the design wins unless a WB request has starved too long.
//
// state   | meaning
// --------+-------------------------------------------------------------
// WB_IDLE | no WB access in flight; a WB request may win arbitration
// WB_DATA | WB access issued last cycle; sram_q carries its read data
// WB_ACK  | ack pulse to the Wishbone master
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = SRAM_AW,
  parameter int DW           = SRAM_DW
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,

  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic          sram_sel_i,
  input  logic [AW-1:0] wbs_adr_i,
  input  logic [DW-1:0] wbs_dat_i,
  output logic [31:0]   wbs_dat_o,
  output logic          wbs_ack_o,

  input  logic          dsg_en,
  input  logic          dsg_req,
  input  logic          dsg_we,
  input  logic [AW-1:0] dsg_addr,
  input  logic [DW-1:0] dsg_wdata,
  output logic          dsg_gnt,
  output logic [DW-1:0] dsg_rdata,
  output logic          dsg_rvalid,

  output logic          sram_cen,
  output logic          sram_gwen,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_d,
  input  logic [DW-1:0] sram_q
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  wb_state_e  state;
  wb_state_e  state_next;
  logic [3:0] starve_cnt;
  logic       wb_we_q;
  logic       wb_req;
  logic       wb_win;
  logic       starved;

  // Strobe is only honoured in IDLE, so a master holding stb through ack
  // cannot trigger a second access.
  assign wb_req  = wbs_cyc_i & wbs_stb_i & sram_sel_i & (state == WB_IDLE);
  assign starved = (starve_cnt == STARVE_MAX);
  assign wb_win  = wb_req & (~dsg_en | ~dsg_req | starved);
  assign dsg_gnt = dsg_en & dsg_req & ~wb_win;

  always_comb begin
    state_next = state;
    case (state)
      WB_IDLE: if (wb_win) state_next = WB_DATA;
      WB_DATA: state_next = WB_ACK;
      WB_ACK:  state_next = WB_IDLE;
      default: state_next = WB_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= WB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      starve_cnt <= 4'd0;
    end else if (!wb_req || wb_win) begin
      starve_cnt <= 4'd0;
    end else if (!starved) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_a    = '0;
    sram_d    = '0;
    if (wb_win) begin
      sram_cen  = 1'b0;
      sram_gwen = ~wbs_we_i;
      sram_a    = wbs_adr_i;
      sram_d    = wbs_dat_i;
    end else if (dsg_gnt) begin
      sram_cen  = 1'b0;
      sram_gwen = ~dsg_we;
      sram_a    = dsg_addr;
      sram_d    = dsg_wdata;
    end
    if (wb_rst_i) begin
      sram_cen  = 1'b1;
      sram_gwen = 1'b1;
    end
  end

  // sram_q in DATA belongs to the WB access; a design access issued in DATA
  // returns its Q one cycle later, during ACK.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_we_q   <= 1'b0;
      wbs_dat_o <= 32'h0;
      wbs_ack_o <= 1'b0;
    end else begin
      if (wb_win) begin
        wb_we_q <= wbs_we_i;
      end
      if (state == WB_DATA && !wb_we_q) begin
        wbs_dat_o <= {{(32-DW){1'b0}}, sram_q};
      end
      wbs_ack_o <= (state == WB_DATA);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      dsg_rvalid <= 1'b0;
    end else begin
      dsg_rvalid <= dsg_gnt & ~dsg_we;
    end
  end

  assign dsg_rdata = sram_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural dffram and
// scoreboard queues for WB acks and design read data.
module tb_sram_port_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int AW = 6;
  localparam int DW = 8;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i;
  logic          wbs_cyc_i, wbs_stb_i, wbs_we_i, sram_sel_i;
  logic [AW-1:0] wbs_adr_i;
  logic [DW-1:0] wbs_dat_i;
  logic [31:0]   wbs_dat_o;
  logic          wbs_ack_o;
  logic          dsg_en, dsg_req, dsg_we;
  logic [AW-1:0] dsg_addr;
  logic [DW-1:0] dsg_wdata;
  logic          dsg_gnt;
  logic [DW-1:0] dsg_rdata;
  logic          dsg_rvalid;
  logic          sram_cen, sram_gwen;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] dat;
    int          lat;
  } wb_exp_t;

  wb_exp_t     wb_q[$];
  logic [7:0]  dsg_q[$];
  logic [7:0]  mem [64];

  always #5 wb_clk_i = ~wb_clk_i;

  sram_port_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .AW(AW),
    .DW(DW)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_we_i  (wbs_we_i),
    .sram_sel_i(sram_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_dat_o (wbs_dat_o),
    .wbs_ack_o (wbs_ack_o),
    .dsg_en    (dsg_en),
    .dsg_req   (dsg_req),
    .dsg_we    (dsg_we),
    .dsg_addr  (dsg_addr),
    .dsg_wdata (dsg_wdata),
    .dsg_gnt   (dsg_gnt),
    .dsg_rdata (dsg_rdata),
    .dsg_rvalid(dsg_rvalid),
    .sram_cen  (sram_cen),
    .sram_gwen (sram_gwen),
    .sram_a    (sram_a),
    .sram_d    (sram_d),
    .sram_q    (sram_q)
  );

  // Behavioural dffram: registered Q, write data shows on Q after a write.
  always @(posedge wb_clk_i) begin
    if (!sram_cen) begin
      if (!sram_gwen) begin
        mem[sram_a] <= sram_d;
        sram_q      <= sram_d;
      end else begin
        sram_q <= mem[sram_a];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic wb_idle();
    wbs_cyc_i  = 1'b0;
    wbs_stb_i  = 1'b0;
    wbs_we_i   = 1'b0;
    sram_sel_i = 1'b0;
    wbs_adr_i  = '0;
    wbs_dat_i  = '0;
  endtask

  // Runs one WB transaction with stb held through the ack cycle.
  task automatic wb_txn(input string tag, input logic we, input logic [5:0] a,
                        input logic [7:0] d, input logic [31:0] exp_dat,
                        input int exp_lat, output logic [7:0] gnt_hist);
    wb_exp_t e;
    int      cyc_n;
    int      acc;
    int      wr;
    logic    got;
    wb_q.push_back('{dat: exp_dat, lat: exp_lat});
    wbs_cyc_i  = 1'b1;
    wbs_stb_i  = 1'b1;
    sram_sel_i = 1'b1;
    wbs_we_i   = we;
    wbs_adr_i  = a;
    wbs_dat_i  = d;
    cyc_n = 0; acc = 0; wr = 0; got = 1'b0; gnt_hist = '0;
    while (!got && cyc_n < 20) begin
      @(negedge wb_clk_i);
      if (cyc_n < 8) gnt_hist[cyc_n] = dsg_gnt;
      if (!sram_cen && !dsg_gnt) begin
        acc++;
        if (!sram_gwen) wr++;
      end
      if (wbs_ack_o) got = 1'b1;
      else cyc_n++;
      next_cycle();
    end
    e = wb_q.pop_front();
    chk({tag, "_ack_seen"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(cyc_n), 32'(e.lat));
    chk({tag, "_dat_o"}, wbs_dat_o, e.dat);
    chk({tag, "_wb_accesses"}, 32'(acc), 32'd1);
    chk({tag, "_gwen_low_cycles"}, 32'(wr), we ? 32'd1 : 32'd0);
    wb_idle();
    @(negedge wb_clk_i);
    chk({tag, "_single_ack"}, 32'(wbs_ack_o), 32'd0);
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] gh;
    logic [7:0] exp_gh;

    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    sram_q = 8'h00;
    wb_idle();
    dsg_en = 1'b0; dsg_req = 1'b0; dsg_we = 1'b0; dsg_addr = '0; dsg_wdata = '0;
    wb_rst_i = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge wb_clk_i);
    chk("rst_ack", 32'(wbs_ack_o), 32'd0);
    chk("rst_dat_o", wbs_dat_o, 32'h0);
    chk("rst_rvalid", 32'(dsg_rvalid), 32'd0);
    chk("rst_cen", 32'(sram_cen), 32'd1);
    chk("rst_gwen", 32'(sram_gwen), 32'd1);
    chk("rst_starve", 32'(dut.starve_cnt), 32'd0);
    next_cycle();
    wb_rst_i = 1'b0;
    next_cycle();

    // Uncontested write then read-back.
    wb_txn("wr_a5", 1'b1, 6'd3, 8'hA5, 32'h0, 2, gh);
    wb_txn("rd_a5", 1'b0, 6'd3, 8'h00, 32'h0000_00A5, 2, gh);

    // Starvation: design streams reads; WB wins on the (LIMIT+1)th cycle.
    dsg_en = 1'b1; dsg_req = 1'b1; dsg_we = 1'b0; dsg_addr = 6'd0;
    wb_txn("starve_rd", 1'b0, 6'd3, 8'h00, 32'h0000_00A5, STARVE_LIMIT + 2, gh);
    exp_gh = '0;
    for (int i = 0; i <= STARVE_LIMIT + 2; i++) exp_gh[i] = (i != STARVE_LIMIT);
    chk("starve_gnt_pattern", 32'(gh), 32'(exp_gh));
    chk("starve_cnt_cleared", 32'(dut.starve_cnt), 32'd0);
    @(negedge wb_clk_i);
    chk("starve_gnt_after", 32'(dsg_gnt), 32'd1);
    next_cycle();

    // Design port disabled: requests ignored, WB at minimum latency.
    dsg_en = 1'b0; dsg_req = 1'b1;
    wb_txn("dis_wr", 1'b1, 6'd7, 8'h5A, 32'h0000_00A5, 2, gh);
    chk("dis_wr_no_gnt", 32'(gh), 32'd0);
    wb_txn("dis_rd", 1'b0, 6'd7, 8'h00, 32'h0000_005A, 2, gh);
    chk("dis_rd_no_gnt", 32'(gh), 32'd0);

    // Design write, WB read next cycle, design read overlapping WB DATA.
    dsg_en = 1'b1; dsg_req = 1'b1; dsg_we = 1'b1; dsg_addr = 6'd10; dsg_wdata = 8'h3C;
    @(negedge wb_clk_i);
    chk("dw_gnt", 32'(dsg_gnt), 32'd1);
    chk("dw_gwen", 32'(sram_gwen), 32'd0);
    chk("dw_addr", 32'(sram_a), 32'd10);
    chk("dw_data", 32'(sram_d), 32'h3C);
    next_cycle();
    dsg_req = 1'b0; dsg_we = 1'b0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; sram_sel_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 6'd10;
    wb_q.push_back('{dat: 32'h0000_003C, lat: 2});
    @(negedge wb_clk_i);
    chk("ov_wb_issue_cen", 32'(sram_cen), 32'd0);
    chk("ov_wb_issue_addr", 32'(sram_a), 32'd10);
    next_cycle();
    dsg_req = 1'b1; dsg_addr = 6'd10;
    dsg_q.push_back(8'h3C);
    @(negedge wb_clk_i);
    chk("ov_dsg_gnt_in_data", 32'(dsg_gnt), 32'd1);
    chk("ov_ack_in_data", 32'(wbs_ack_o), 32'd0);
    next_cycle();
    dsg_req = 1'b0;
    @(negedge wb_clk_i);
    begin
      wb_exp_t e;
      e = wb_q.pop_front();
      chk("ov_ack", 32'(wbs_ack_o), 32'd1);
      chk("ov_wb_dat", wbs_dat_o, e.dat);
    end
    chk("ov_rvalid", 32'(dsg_rvalid), 32'd1);
    chk("ov_rdata", 32'(dsg_rdata), 32'(dsg_q.pop_front()));
    next_cycle();
    wb_idle();
    @(negedge wb_clk_i);
    chk("ov_ack_done", 32'(wbs_ack_o), 32'd0);
    chk("ov_rvalid_done", 32'(dsg_rvalid), 32'd0);
    next_cycle();

    // Back-to-back design reads, then dsg_en drops with an rvalid in flight.
    dsg_req = 1'b1; dsg_we = 1'b0; dsg_addr = 6'd3;
    dsg_q.push_back(8'hA5);
    next_cycle();
    dsg_addr = 6'd10;
    dsg_q.push_back(8'h3C);
    @(negedge wb_clk_i);
    chk("b2b_rvalid0", 32'(dsg_rvalid), 32'd1);
    chk("b2b_rdata0", 32'(dsg_rdata), 32'(dsg_q.pop_front()));
    next_cycle();
    dsg_en = 1'b0;
    @(negedge wb_clk_i);
    chk("en_drop_gnt", 32'(dsg_gnt), 32'd0);
    chk("en_drop_cen", 32'(sram_cen), 32'd1);
    chk("b2b_rvalid1", 32'(dsg_rvalid), 32'd1);
    chk("b2b_rdata1", 32'(dsg_rdata), 32'(dsg_q.pop_front()));
    next_cycle();
    @(negedge wb_clk_i);
    chk("en_drop_rvalid_end", 32'(dsg_rvalid), 32'd0);
    next_cycle();
    dsg_req = 1'b0;

    // Reset during the DATA cycle of a WB read, with a design read pending.
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; sram_sel_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 6'd7;
    next_cycle();
    wb_rst_i = 1'b1;
    dsg_en = 1'b1; dsg_req = 1'b1; dsg_we = 1'b0; dsg_addr = 6'd3;
    @(negedge wb_clk_i);
    chk("rstd_cen_forced", 32'(sram_cen), 32'd1);
    next_cycle();
    wb_rst_i = 1'b0;
    wb_idle();
    dsg_en = 1'b0; dsg_req = 1'b0;
    @(negedge wb_clk_i);
    chk("rstd_no_ack", 32'(wbs_ack_o), 32'd0);
    chk("rstd_dat_o", wbs_dat_o, 32'h0);
    chk("rstd_cen", 32'(sram_cen), 32'd1);
    chk("rstd_gwen", 32'(sram_gwen), 32'd1);
    chk("rstd_rvalid", 32'(dsg_rvalid), 32'd0);
    next_cycle();
    @(negedge wb_clk_i);
    chk("rstd_no_late_ack", 32'(wbs_ack_o), 32'd0);
    next_cycle();
    wb_txn("post_rst_rd", 1'b0, 6'd3, 8'h00, 32'h0000_00A5, 2, gh);

    chk("wb_queue_drained", 32'(wb_q.size()), 32'd0);
    chk("dsg_queue_drained", 32'(dsg_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
